// File: rtl/pit8253_arbiter.sv
// Arbiter between the CPU port and a background player FIFO for the 8253 bus.
// Define PIT8253_ARB_COLLIDE_EN to keep a sticky collision flag.
module pit8253_arbiter #(
    parameter int FIFO_AW = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce,
    input  logic [1:0] cpu_a,
    input  logic       cpu_wr,
    input  logic       cpu_rd,
    input  logic [7:0] cpu_din,
    output logic [7:0] cpu_dout,
    input  logic       pl_push,
    input  logic [1:0] pl_a,
    input  logic [7:0] pl_d,
    output logic       pl_full,
    output logic       pl_empty,
    output logic       pl_ovf,
    output logic [1:0] pit_a,
    output logic       pit_wr,
    output logic       pit_rd,
    output logic [7:0] pit_din,
    input  logic [7:0] pit_dout,
    output logic       collision
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW + 1)'(DEPTH);
    localparam logic [FIFO_AW:0] TWO_CNT = (FIFO_AW + 1)'(2);

    typedef enum logic {
        S_IDLE,
        S_PAIR
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         pair_n_q, pair_n_d;
    logic [9:0]         mem_q [DEPTH];
    logic [FIFO_AW-1:0] wp_q, wp_d;
    logic [FIFO_AW-1:0] rp_q, rp_d;
    logic [FIFO_AW:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic [2:0][1:0]    rl_q, rl_d;
    logic [2:0]         tog_q, tog_d;
    logic [2:0]         tcpu_q, tcpu_d;

    logic       cpu_act;
    logic       full;
    logic       empty;
    logic       lock;
    logic [1:0] head_a;
    logic [7:0] head_d;
    logic [3:0] pairable;
    logic       head_pair;
    logic       pl_rdy;
    logic       pl_iss;
    logic [1:0] cpu_n;
    logic       cpu_hit;
    logic       abort;
    logic       pop;
    logic       push_ok;
    logic       iss_wr;

    assign cpu_act  = cpu_wr | cpu_rd;
    assign cpu_dout = pit_dout;
    assign full     = (cnt_q == FULL_CNT);
    assign empty    = (cnt_q == '0);
    assign pl_full  = full;
    assign pl_empty = empty;
    assign pl_ovf   = ovf_q;

    assign head_a = mem_q[rp_q][9:8];
    assign head_d = mem_q[rp_q][7:0];

    // A counter is locked while its LSB came from the CPU and the MSB has not.
    assign lock = |(tog_q & tcpu_q);

    always_comb begin
        pairable = 4'b0000;
        for (int n = 0; n < 3; n++) begin
            pairable[n] = (rl_q[n] == 2'd3) && !tog_q[n];
        end
    end

    assign head_pair = pairable[head_a];

    always_comb begin
        pl_rdy = 1'b0;
        if (!empty) begin
            if (state_q == S_PAIR) begin
                pl_rdy = 1'b1;
            end else begin
                pl_rdy = !lock && (!head_pair || cnt_q >= TWO_CNT);
            end
        end
    end

    assign pl_iss = ce && !reset && !cpu_act && pl_rdy;

    assign cpu_n   = (cpu_a == 2'd3) ? cpu_din[7:6] : cpu_a;
    assign cpu_hit = (cpu_n == pair_n_q);
    assign abort   = ce && !reset && cpu_wr
                     && (state_q == S_PAIR) && cpu_hit;

    assign pop     = pl_iss || (abort && !empty);
    assign push_ok = pl_push && (!full || pop);
    assign iss_wr  = ce && !reset && (cpu_wr || pl_iss);

    always_comb begin
        pit_a   = 2'd0;
        pit_wr  = 1'b0;
        pit_rd  = 1'b0;
        pit_din = 8'd0;
        if (cpu_act) begin
            pit_a   = cpu_a;
            pit_wr  = cpu_wr;
            pit_rd  = cpu_rd;
            pit_din = cpu_din;
        end else if (pl_iss) begin
            pit_a   = head_a;
            pit_wr  = 1'b1;
            pit_din = head_d;
        end
    end

    // Shadow of the timer's read/load mode and LSB/MSB toggle.
    always_comb begin
        rl_d   = rl_q;
        tog_d  = tog_q;
        tcpu_d = tcpu_q;
        if (iss_wr) begin
            for (int n = 0; n < 3; n++) begin
                if (pit_a == 2'd3) begin
                    if (pit_din[7:6] == 2'(n) && pit_din[5:4] != 2'd0) begin
                        rl_d[n]   = pit_din[5:4];
                        tog_d[n]  = 1'b0;
                        tcpu_d[n] = 1'b0;
                    end
                end else if (pit_a == 2'(n) && rl_q[n] == 2'd3) begin
                    tog_d[n]  = ~tog_q[n];
                    tcpu_d[n] = cpu_act;
                end
            end
        end
    end

    always_comb begin
        wp_d  = push_ok ? wp_q + 1'b1 : wp_q;
        rp_d  = pop ? rp_q + 1'b1 : rp_q;
        ovf_d = ovf_q | (pl_push & full & ~pop);
        unique case ({push_ok, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        pair_n_d = pair_n_q;
        if (abort) begin
            state_d = S_IDLE;
        end else if (pl_iss) begin
            if (state_q == S_IDLE && head_pair) begin
                state_d  = S_PAIR;
                pair_n_d = head_a;
            end else begin
                state_d = S_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            pair_n_q <= 2'd0;
            wp_q     <= '0;
            rp_q     <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            rl_q     <= '0;
            tog_q    <= 3'b000;
            tcpu_q   <= 3'b000;
        end else begin
            state_q  <= state_d;
            pair_n_q <= pair_n_d;
            wp_q     <= wp_d;
            rp_q     <= rp_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            rl_q     <= rl_d;
            tog_q    <= tog_d;
            tcpu_q   <= tcpu_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wp_q] <= {pl_a, pl_d};
        end
    end

`ifdef PIT8253_ARB_COLLIDE_EN
    logic coll_q, coll_d;

    assign coll_d = coll_q | abort;

    always_ff @(posedge clk) begin
        if (reset) begin
            coll_q <= 1'b0;
        end else begin
            coll_q <= coll_d;
        end
    end

    assign collision = coll_q;
`else
    assign collision = 1'b0;
`endif

endmodule

// File: tb/tb_pit8253_arbiter.sv
// Bench for pit8253_arbiter: directed scenarios plus random traffic
// checked against a queue-based model of the arbitration rules.
module tb_pit8253_arbiter;

    localparam int AW = 3;
    localparam int DEPTH = 1 << AW;

    logic       clk = 1'b0;
    logic       reset;
    logic       ce;
    logic [1:0] cpu_a;
    logic       cpu_wr;
    logic       cpu_rd;
    logic [7:0] cpu_din;
    logic [7:0] cpu_dout;
    logic       pl_push;
    logic [1:0] pl_a;
    logic [7:0] pl_d;
    logic       pl_full;
    logic       pl_empty;
    logic       pl_ovf;
    logic [1:0] pit_a;
    logic       pit_wr;
    logic       pit_rd;
    logic [7:0] pit_din;
    logic [7:0] pit_dout;
    logic       collision;

    int n_pass = 0;
    int n_tot = 0;

    logic [9:0] mq[$];
    logic [1:0] m_rl [3];
    logic       m_tog [3];
    logic       m_cpu [3];
    logic       m_pair;
    logic [1:0] m_pn;
    logic       m_ovf;
    logic       m_coll;
    logic       coll_en;

    pit8253_arbiter #(.FIFO_AW(AW)) dut (
        .clk(clk),
        .reset(reset),
        .ce(ce),
        .cpu_a(cpu_a),
        .cpu_wr(cpu_wr),
        .cpu_rd(cpu_rd),
        .cpu_din(cpu_din),
        .cpu_dout(cpu_dout),
        .pl_push(pl_push),
        .pl_a(pl_a),
        .pl_d(pl_d),
        .pl_full(pl_full),
        .pl_empty(pl_empty),
        .pl_ovf(pl_ovf),
        .pit_a(pit_a),
        .pit_wr(pit_wr),
        .pit_rd(pit_rd),
        .pit_din(pit_din),
        .pit_dout(pit_dout),
        .collision(collision)
    );

    always #5 clk = ~clk;

    function automatic void m_reset();
        mq.delete();
        for (int n = 0; n < 3; n++) begin
            m_rl[n]  = 2'd0;
            m_tog[n] = 1'b0;
            m_cpu[n] = 1'b0;
        end
        m_pair = 1'b0;
        m_pn   = 2'd0;
        m_ovf  = 1'b0;
        m_coll = 1'b0;
    endfunction

    function automatic logic m_lock();
        logic l = 1'b0;
        for (int n = 0; n < 3; n++) begin
            if (m_tog[n] && m_cpu[n]) l = 1'b1;
        end
        return l;
    endfunction

    function automatic logic m_wants_pair(logic [9:0] e);
        if (e[9:8] == 2'd3) return 1'b0;
        return (m_rl[e[9:8]] == 2'd3) && !m_tog[e[9:8]];
    endfunction

    function automatic logic m_go();
        if (reset || !ce || cpu_wr || cpu_rd) return 1'b0;
        if (mq.size() == 0) return 1'b0;
        if (m_pair) return 1'b1;
        if (m_lock()) return 1'b0;
        if (m_wants_pair(mq[0]) && mq.size() < 2) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [11:0] exp_bus();
        if (cpu_wr || cpu_rd) return {cpu_wr, cpu_rd, cpu_a, cpu_din};
        if (m_go()) return {2'b10, mq[0]};
        return 12'd0;
    endfunction

    function automatic logic [3:0] exp_flags();
        return {mq.size() == DEPTH, mq.size() == 0, m_ovf, m_coll};
    endfunction

    function automatic logic [11:0] dut_bus();
        return {pit_wr, pit_rd, pit_a, pit_din};
    endfunction

    function automatic logic [3:0] dut_flags();
        return {pl_full, pl_empty, pl_ovf, collision};
    endfunction

    function automatic void m_shadow(logic [1:0] a, logic [7:0] d,
                                     logic by_cpu);
        int n;
        if (a == 2'd3) begin
            n = int'(d[7:6]);
            if (n < 3 && d[5:4] != 2'd0) begin
                m_rl[n]  = d[5:4];
                m_tog[n] = 1'b0;
                m_cpu[n] = 1'b0;
            end
        end else if (m_rl[a] == 2'd3) begin
            m_tog[a] = !m_tog[a];
            m_cpu[a] = by_cpu;
        end
    endfunction

    function automatic void m_clock();
        logic       go;
        logic       abort;
        logic [9:0] h;
        logic [1:0] tgt;
        if (reset) begin
            m_reset();
            return;
        end
        go    = m_go();
        h     = (mq.size() != 0) ? mq[0] : 10'd0;
        tgt   = (cpu_a == 2'd3) ? cpu_din[7:6] : cpu_a;
        abort = ce && cpu_wr && m_pair && (tgt == m_pn);
        if (go) begin
            void'(mq.pop_front());
            if (m_pair) begin
                m_pair = 1'b0;
            end else if (m_wants_pair(h)) begin
                m_pair = 1'b1;
                m_pn   = h[9:8];
            end
        end
        if (abort) begin
            if (mq.size() != 0) void'(mq.pop_front());
            m_pair = 1'b0;
            if (coll_en) m_coll = 1'b1;
        end
        if (ce && cpu_wr) m_shadow(cpu_a, cpu_din, 1'b1);
        else if (go) m_shadow(h[9:8], h[7:0], 1'b0);
        if (pl_push) begin
            if (mq.size() < DEPTH) mq.push_back({pl_a, pl_d});
            else m_ovf = 1'b1;
        end
    endfunction

    task automatic tick();
        m_clock();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cpu_wr  = 1'b0;
        cpu_rd  = 1'b0;
        pl_push = 1'b0;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        ce       = 1'b1;
        cpu_a    = 2'd0;
        cpu_din  = 8'd0;
        pl_a     = 2'd0;
        pl_d     = 8'd0;
        pit_dout = 8'd0;
        idle();
        tick();
        tick();
        reset = 1'b0;
        #1;
        n_tot++;
        if (dut_flags() !== 4'b0100)
            $display("FAIL reset_flags: got %b want %b", dut_flags(), 4'b0100);
        else n_pass++;
        n_tot++;
        if (dut_bus() !== 12'd0)
            $display("FAIL reset_bus: got %h want %h", dut_bus(), 12'd0);
        else n_pass++;
    endtask

    task automatic test_cpu_pass();
        logic [1:0] ta [3] = '{2'd3, 2'd0, 2'd0};
        logic [7:0] td [3] = '{8'h36, 8'h34, 8'h12};
        logic [7:0] rd_v;
        ce = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cpu_a   = ta[i];
            cpu_din = td[i];
            cpu_wr  = 1'b1;
            #1;
            n_tot++;
            if (dut_bus() !== {2'b10, ta[i], td[i]})
                $display("FAIL cpu_wr_pass %0d: got %h want %h",
                         i, dut_bus(), {2'b10, ta[i], td[i]});
            else n_pass++;
            tick();
        end
        idle();
        rd_v     = 8'($urandom);
        pit_dout = rd_v;
        cpu_a    = 2'd0;
        cpu_rd   = 1'b1;
        #1;
        n_tot++;
        if (cpu_dout !== rd_v)
            $display("FAIL cpu_rd_data: got %h want %h", cpu_dout, rd_v);
        else n_pass++;
        n_tot++;
        if ({pit_wr, pit_rd, pit_a} !== 4'b0100)
            $display("FAIL cpu_rd_strobe: got %b want %b",
                     {pit_wr, pit_rd, pit_a}, 4'b0100);
        else n_pass++;
        tick();
        idle();
        // rl[0]=3 with tog[0]=0 means a lone LSB to counter 0 is held.
        pl_push = 1'b1;
        pl_a    = 2'd0;
        pl_d    = 8'h77;
        tick();
        pl_push = 1'b0;
        #1;
        n_tot++;
        if (pit_wr !== 1'b0)
            $display("FAIL c0_lsb_held: got %b want 0", pit_wr);
        else n_pass++;
        tick();
        pl_push = 1'b1;
        pl_d    = 8'h00;
        tick();
        pl_push = 1'b0;
        #1;
        n_tot++;
        if (dut_bus() !== 12'h877)
            $display("FAIL c0_lsb: got %h want %h", dut_bus(), 12'h877);
        else n_pass++;
        tick();
        n_tot++;
        if (dut_bus() !== 12'h800)
            $display("FAIL c0_msb: got %h want %h", dut_bus(), 12'h800);
        else n_pass++;
        tick();
    endtask

    task automatic test_player_seq();
        logic [11:0] want [3] = '{12'hB76, 12'h900, 12'h910};
        idle();
        ce = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pl_push = 1'b1;
            pl_a    = want[i][9:8];
            pl_d    = want[i][7:0];
            tick();
        end
        idle();
        ce = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_tot++;
            if (dut_bus() !== want[i])
                $display("FAIL player_seq %0d: got %h want %h",
                         i, dut_bus(), want[i]);
            else n_pass++;
            tick();
        end
        n_tot++;
        if ({pl_empty, pit_wr} !== 2'b10)
            $display("FAIL player_seq_done: got %b want %b",
                     {pl_empty, pit_wr}, 2'b10);
        else n_pass++;
    endtask

    task automatic test_lsb_wait();
        idle();
        ce      = 1'b1;
        pl_push = 1'b1;
        pl_a    = 2'd1;
        pl_d    = 8'hAA;
        tick();
        pl_push = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_tot++;
            if (pit_wr !== 1'b0)
                $display("FAIL lsb_wait %0d: got %b want 0", i, pit_wr);
            else n_pass++;
            tick();
        end
        pl_push = 1'b1;
        pl_d    = 8'hBB;
        tick();
        pl_push = 1'b0;
        #1;
        n_tot++;
        if (dut_bus() !== 12'h9AA)
            $display("FAIL lsb_wait_lsb: got %h want %h", dut_bus(), 12'h9AA);
        else n_pass++;
        tick();
        n_tot++;
        if (dut_bus() !== 12'h9BB)
            $display("FAIL lsb_wait_msb: got %h want %h", dut_bus(), 12'h9BB);
        else n_pass++;
        tick();
    endtask

    task automatic test_collision();
        idle();
        ce = 1'b0;
        pl_a    = 2'd1;
        pl_push = 1'b1;
        pl_d    = 8'h11;
        tick();
        pl_d    = 8'h22;
        tick();
        idle();
        ce = 1'b1;
        #1;
        n_tot++;
        if (dut_bus() !== 12'h911)
            $display("FAIL coll_lsb: got %h want %h", dut_bus(), 12'h911);
        else n_pass++;
        tick();
        cpu_wr  = 1'b1;
        cpu_a   = 2'd1;
        cpu_din = 8'h55;
        tick();
        idle();
        #1;
        n_tot++;
        if ({collision, pl_empty, pit_wr} !== {coll_en, 2'b10})
            $display("FAIL coll_abort: got %b want %b",
                     {collision, pl_empty, pit_wr}, {coll_en, 2'b10});
        else n_pass++;
        // Back in idle: a fresh lone LSB must be held again.
        pl_push = 1'b1;
        pl_d    = 8'h33;
        tick();
        pl_push = 1'b0;
        #1;
        n_tot++;
        if (pit_wr !== 1'b0)
            $display("FAIL coll_idle_hold: got %b want 0", pit_wr);
        else n_pass++;
        pl_push = 1'b1;
        pl_d    = 8'h44;
        tick();
        pl_push = 1'b0;
        #1;
        n_tot++;
        if (dut_bus() !== 12'h933)
            $display("FAIL coll_relsb: got %h want %h", dut_bus(), 12'h933);
        else n_pass++;
        tick();
        n_tot++;
        if (dut_bus() !== 12'h944)
            $display("FAIL coll_remsb: got %h want %h", dut_bus(), 12'h944);
        else n_pass++;
        tick();
    endtask

    task automatic test_cpu_lock();
        idle();
        ce      = 1'b1;
        cpu_wr  = 1'b1;
        cpu_a   = 2'd3;
        cpu_din = 8'hB6;
        tick();
        cpu_a   = 2'd2;
        cpu_din = 8'h01;
        tick();
        idle();
        pl_push = 1'b1;
        pl_a    = 2'd3;
        pl_d    = 8'h40;
        tick();
        pl_push = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_tot++;
            if (pit_wr !== 1'b0)
                $display("FAIL cpu_lock_hold %0d: got %b want 0", i, pit_wr);
            else n_pass++;
            tick();
        end
        cpu_wr  = 1'b1;
        cpu_a   = 2'd2;
        cpu_din = 8'h02;
        tick();
        idle();
        #1;
        n_tot++;
        if (dut_bus() !== 12'hB40)
            $display("FAIL cpu_lock_release: got %h want %h",
                     dut_bus(), 12'hB40);
        else n_pass++;
        tick();
    endtask

    task automatic test_overflow();
        logic [7:0] vals [DEPTH + 1];
        idle();
        ce = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            vals[i] = {2'($urandom), 2'b00, 4'($urandom)};
            pl_push = 1'b1;
            pl_a    = 2'd3;
            pl_d    = vals[i];
            tick();
        end
        idle();
        n_tot++;
        if ({pl_full, pl_empty, pl_ovf} !== 3'b101)
            $display("FAIL ovf_flags: got %b want %b",
                     {pl_full, pl_empty, pl_ovf}, 3'b101);
        else n_pass++;
        ce = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            #1;
            n_tot++;
            if (dut_bus() !== {4'b1011, vals[i]})
                $display("FAIL ovf_drain %0d: got %h want %h",
                         i, dut_bus(), {4'b1011, vals[i]});
            else n_pass++;
            tick();
        end
        n_tot++;
        if ({pl_full, pl_empty, pl_ovf, pit_wr} !== 4'b0110)
            $display("FAIL ovf_after: got %b want %b",
                     {pl_full, pl_empty, pl_ovf, pit_wr}, 4'b0110);
        else n_pass++;
    endtask

    task automatic test_random(int cycles, int push_pct);
        int r;
        for (int i = 0; i < cycles; i++) begin
            reset    = ($urandom_range(0, 249) == 0);
            ce       = ($urandom_range(0, 3) != 0);
            r        = $urandom_range(0, 9);
            cpu_wr   = (r == 0);
            cpu_rd   = (r == 1);
            cpu_a    = 2'($urandom);
            cpu_din  = 8'($urandom);
            pl_push  = ($urandom_range(0, 99) < push_pct);
            pl_a     = 2'($urandom);
            pl_d     = 8'($urandom);
            pit_dout = 8'($urandom);
            #1;
            n_tot++;
            if (dut_bus() !== exp_bus())
                $display("FAIL rand_bus @%0d: got %h want %h",
                         i, dut_bus(), exp_bus());
            else n_pass++;
            n_tot++;
            if (dut_flags() !== exp_flags())
                $display("FAIL rand_flags @%0d: got %b want %b",
                         i, dut_flags(), exp_flags());
            else n_pass++;
            n_tot++;
            if (cpu_dout !== pit_dout)
                $display("FAIL rand_dout @%0d: got %h want %h",
                         i, cpu_dout, pit_dout);
            else n_pass++;
            tick();
        end
        reset = 1'b0;
        idle();
    endtask

    initial begin
`ifdef PIT8253_ARB_COLLIDE_EN
        coll_en = 1'b1;
`else
        coll_en = 1'b0;
`endif
        m_reset();
        test_reset();
        test_cpu_pass();
        test_player_seq();
        test_lsb_wait();
        test_collision();
        test_cpu_lock();
        test_overflow();
        test_random(1500, 40);
        test_random(1500, 90);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/pit8253_arbiter.md
# pit8253_arbiter

Bus arbiter and sequencer between the CPU I/O port and the three-channel 8253 timer. It shares the timer's register bus between the CPU, which always has priority and is never stalled, and a background sound player that queues register writes in a small FIFO. It also tracks the timer's LSB/MSB load toggles so that a player's 16-bit count load is issued as an uninterrupted pair. It sits between the I/O decode and the `pit8253` instance and is clocked on the same bus clock enable.

## Interface
Parameters:
- `FIFO_AW`, default 3: FIFO address width; depth is 2^FIFO_AW entries.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `ce` in 1: bus clock enable; one timer bus slot per `ce` cycle.
- `cpu_a` in 2: CPU register address.
- `cpu_wr` in 1: CPU write strobe.
- `cpu_rd` in 1: CPU read strobe.
- `cpu_din` in 8: CPU write data.
- `cpu_dout` out 8: CPU read data.
- `pl_push` in 1: player write request (FIFO push).
- `pl_a` in 2: player register address.
- `pl_d` in 8: player data.
- `pl_full` out 1: FIFO full.
- `pl_empty` out 1: FIFO empty.
- `pl_ovf` out 1: sticky overflow; a push was attempted while full.
- `pit_a` out 2: timer address.
- `pit_wr` out 1: timer write.
- `pit_rd` out 1: timer read.
- `pit_din` out 8: timer write data.
- `pit_dout` in 8: timer read data.
- `collision` out 1: sticky collision flag (see Configuration).

## Operation
Slot ownership:
- A slot is a cycle with `ce`=1.
- If `cpu_wr` or `cpu_rd` is high, the CPU owns the slot. `pit_*` is driven combinationally from `cpu_*`.
- Otherwise the player may own the slot. `pit_a` and `pit_din` come from the FIFO head, `pit_wr`=1, and the head is popped at the end of the slot.
- When no owner exists, `pit_wr` and `pit_rd` are 0.
- `cpu_dout` equals `pit_dout` combinationally.

Shadow state (per counter n = 0..2), updated on every issued write from either source:
- Control write (a=3, d[7:6]=n, d[5:4]≠0): `rl[n]`←d[5:4], `tog[n]`←0.
- Latch command (d[5:4]=0): no change.
- Data write to counter n with `rl[n]`=3: `tog[n]` flips.
- `cpu_lock` is set when any `tog[n]` was set by a CPU write, meaning the CPU has an LSB pending.

FSM:
- `S_IDLE`
  - The player is blocked while `cpu_lock` is set or the FIFO is empty.
  - If the head is a data write to n with `rl[n]`=3 and `tog[n]`=0, the player issues it only when the FIFO count ≥2, then goes to `S_PAIR`.
  - Any other head is issued singly and the FSM stays in `S_IDLE`.
- `S_PAIR`
  - The next player-owned slot issues the head as the MSB, then the FSM returns to `S_IDLE`.
  - If a CPU write targets counter n (data at a=n, or a control word selecting n) while in `S_PAIR`, the FSM pops and discards the pending MSB entry without issuing it, sets `collision`, and returns to `S_IDLE`.

FIFO:
- A push while full is dropped and sets `pl_ovf`.
- A simultaneous push and pop when full is accepted.
- A push to an empty FIFO can be issued in the following slot, not in the same cycle.

Reset values:
- FIFO empty; `pl_empty`=1, `pl_full`=0, `pl_ovf`=0, `collision`=0.
- `rl[*]`=0 (treated as single-byte), `tog[*]`=0.
- State `S_IDLE`.
- `pit_wr`=0 and `pit_rd`=0 while no CPU strobe is present.
- A reset in `S_PAIR` discards the pair; the queued MSB entry is lost.

## Timing
- CPU path: zero latency, combinational pass-through within the same `ce` cycle.
- Player path: minimum 1 slot from push to issue. A 16-bit pair occupies two consecutive player-owned slots, which may be separated by CPU slots.
- Flags update on the `clk` edge ending the slot.
- FIFO pointers wrap modulo 2^FIFO_AW.

## Configuration
- `PIT8253_ARB_COLLIDE_EN` defined: the `collision` register is present, sticky, and cleared only by `reset`.
- Not defined: `collision` is tied to 0.
- The abort-on-collision behaviour is identical in both builds.

## Test plan
- Reset, then CPU writes a=3 d=0x36, a=0 d=0x34, a=0 d=0x12 → `pit_*` mirrors each in the same cycle, shadow `rl[0]`=3, `tog[0]` returns to 0.
- Player pushes control 0x76, then 0x00, 0x10 to a=1 → issued in 3 consecutive idle slots; LSB and MSB back-to-back; `pl_empty`=1 afterwards.
- Player pushes LSB only, with `rl[1]`=3 → no issue until the MSB is pushed; then both are issued in successive slots.
- Player LSB issued; CPU writes a=1 d=0x55 in the next slot → MSB discarded, `collision`=1 (with macro defined), FSM returns to `S_IDLE`.
- CPU writes LSB to counter 2 (`rl`=3) and stalls; player FIFO holds writes → no player issue until the CPU's MSB arrives.
- 2^FIFO_AW+1 pushes with `ce`=0 → `pl_full`=1, `pl_ovf`=1; the first 2^FIFO_AW entries drain in order once `ce` runs.
